led_band_sequencer: RTL and testbench

LED_BAND_SEQUENCER -- requirements
Module: led_band_sequencer

---
 rtl/led_band_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_led_band_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_band_sequencer.sv
// Double-buffered frame memory feeding N_CH parallel LED band shifters, one angle per start.
// Bit n is on SOUT from edge 2+2n; byte fetch runs one byte ahead so the shifters never stall.
module led_band_sequencer #(
  parameter int N_CH     = 2,
  parameter int N_ROWS   = 32,
  parameter int N_ANGLES = 128,
  parameter int N_COLORS = 3,
  parameter int BPC      = 8,
  parameter int WORD_W   = 128,
  parameter int FC_W     = 48,
  localparam int DEPTH   = N_CH * N_ROWS * N_ANGLES * N_COLORS * BPC / WORD_W,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ANW     = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1,
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write,
  input  logic [AW-1:0]          w_addr,
  input  logic [WORD_W-1:0]      w_data,
  input  logic                   new_frame,
  input  logic                   start,
  input  logic [ANW-1:0]         angle,
  input  logic                   lsb_first,
  input  logic                   hps_override,
  input  logic                   hps_SOUT,
  input  logic                   hps_SCLK,
  input  logic                   hps_LAT,
  input  logic                   hps_fc_write,
  input  logic [CHW-1:0]         hps_fc_addr,
  input  logic [FC_W-1:0]        hps_fc_data,
  output logic                   SCLK,
  output logic                   LAT,
  output logic [N_CH-1:0]        SOUT,
  output logic                   busy,
  output logic                   done,
  output logic                   read_buf,
  output logic [N_CH*FC_W-1:0]   fc_out
);

  localparam int BPW = WORD_W / 8;
  localparam int NBY = N_ROWS * N_COLORS;
  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW  = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;
  localparam int OW  = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int BCW = (BPC > 1) ? $clog2(BPC) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [2][DEPTH];
  logic [FC_W-1:0]   fc_q [N_CH];
  logic [BPC-1:0]    shift_q [N_CH];
  logic [BPC-1:0]    fetch_q [N_CH];
  logic [BPC-1:0]    rd_byte [N_CH];
  logic [N_CH-1:0]   sout_raw;

  logic           go_q, lsb_q, pend_q;
  logic [ANW-1:0] angle_q;
  logic [RW-1:0]  row_f;
  logic [CW-1:0]  col_f;
  logic [OW-1:0]  out_idx;
  logic [BCW-1:0] bcnt, bit_idx;

  logic start_acc, last, byte_end, load_fetch, seq_end, abort, shifting;

  assign busy      = (state != IDLE);
  assign done      = (state == LATCH);
  assign shifting  = (state == SHIFT_LO) || (state == SHIFT_HI);
  assign start_acc = (state == IDLE) && !go_q && start && !hps_override;
  assign byte_end  = (bcnt == BCW'(BPC - 1));
  assign last      = byte_end && (out_idx == OW'(NBY - 1));
  assign load_fetch = ((state == IDLE) && go_q && !hps_override) || (state == FETCH) ||
                      ((state == SHIFT_HI) && byte_end && !last);
  assign seq_end   = (state == SHIFT_HI) && last && !hps_override;
  assign abort     = busy && hps_override;
  assign bit_idx   = lsb_q ? bcnt : BCW'(BPC - 1) - bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (go_q && !hps_override) state_nxt = FETCH;
      FETCH:    state_nxt = SHIFT_LO;
      SHIFT_LO: state_nxt = SHIFT_HI;
      SHIFT_HI: state_nxt = last ? LATCH : SHIFT_LO;
      LATCH:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (hps_override) state_nxt = IDLE;
  end

  // Frame memory is never reset; writes always land in the buffer not being read.
  always_ff @(posedge clk) begin
    if (write && (32'(w_addr) < DEPTH)) mem[~read_buf][w_addr] <= w_data;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [31:0]       baddr, bsel;
    logic [AW-1:0]     widx;
    logic [WORD_W-1:0] word;

    always_comb begin
      baddr = 32'(col_f) + 32'(N_COLORS) * 32'(angle_q) +
              32'(N_COLORS * N_ANGLES) * 32'(row_f) +
              32'(N_COLORS * N_ANGLES * N_ROWS * g);
      widx  = AW'(baddr / 32'(BPW));
      bsel  = baddr % 32'(BPW);
      word  = mem[read_buf][widx];
      rd_byte[g] = '0;
      for (int k = 0; k < BPW; k++)
        if (bsel == 32'(k)) rd_byte[g] = word[8*k +: BPC];
    end

    assign sout_raw[g]               = shift_q[g][bit_idx];
    assign fc_out[g*FC_W +: FC_W]    = fc_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q    <= 1'b0;
      lsb_q   <= 1'b0;
      angle_q <= '0;
      row_f   <= '0;
      col_f   <= '0;
      bcnt    <= '0;
      out_idx <= '0;
      for (int c = 0; c < N_CH; c++) begin
        shift_q[c] <= '0;
        fetch_q[c] <= '0;
      end
    end else begin
      go_q <= start_acc;
      if (start_acc) begin
        angle_q <= angle;
        lsb_q   <= lsb_first;
        row_f   <= '0;
        col_f   <= '0;
      end
      // Prefetch walks colour then row, always one byte ahead of the shifters.
      if (load_fetch) begin
        for (int c = 0; c < N_CH; c++) fetch_q[c] <= rd_byte[c];
        if (col_f == CW'(N_COLORS - 1)) begin
          col_f <= '0;
          row_f <= (row_f == RW'(N_ROWS - 1)) ? '0 : row_f + 1'b1;
        end else begin
          col_f <= col_f + 1'b1;
        end
      end
      if ((state == FETCH) || ((state == SHIFT_HI) && byte_end && !last)) begin
        for (int c = 0; c < N_CH; c++) shift_q[c] <= fetch_q[c];
        bcnt    <= '0;
        out_idx <= (state == FETCH) ? '0 : out_idx + 1'b1;
      end else if (state == SHIFT_HI) begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // A swap requested mid-sequence waits for the latch (or abort) edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_buf <= 1'b1;
      pend_q   <= 1'b0;
    end else if ((seq_end || abort) && (pend_q || new_frame)) begin
      read_buf <= ~read_buf;
      pend_q   <= 1'b0;
    end else if (new_frame && !busy) begin
      read_buf <= ~read_buf;
    end else if (new_frame && busy) begin
      pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) fc_q[c] <= '0;
    end else if (hps_fc_write && (32'(hps_fc_addr) < N_CH)) begin
      fc_q[hps_fc_addr] <= hps_fc_data;
    end
  end

  assign SCLK = hps_override ? hps_SCLK : (state == SHIFT_HI);
  assign LAT  = hps_override ? hps_LAT  : (state == LATCH);
  assign SOUT = hps_override ? {N_CH{hps_SOUT}} : (shifting ? sout_raw : '0);

endmodule

// File: tb/tb_led_band_sequencer.sv
// Scoreboard bench: expected SOUT bits are queued at start and popped on each SCLK rise.
module tb_led_band_sequencer;
  localparam int N_CH = 2, N_ROWS = 2, N_ANGLES = 4, N_COLORS = 3, BPC = 8;
  localparam int WORD_W = 128, FC_W = 48;
  localparam int DEPTH = N_CH * N_ROWS * N_ANGLES * N_COLORS * BPC / WORD_W;
  localparam int BPW = WORD_W / 8;
  localparam int NB = N_ROWS * N_COLORS * BPC;
  localparam int AW = $clog2(DEPTH);
  localparam int ANW = $clog2(N_ANGLES);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic write = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [WORD_W-1:0] w_data = '0;
  logic new_frame = 1'b0, start = 1'b0, lsb_first = 1'b0;
  logic [ANW-1:0] angle = '0;
  logic hps_override = 1'b0, hps_SOUT = 1'b0, hps_SCLK = 1'b0, hps_LAT = 1'b0;
  logic hps_fc_write = 1'b0;
  logic [0:0] hps_fc_addr = '0;
  logic [FC_W-1:0] hps_fc_data = '0;
  logic SCLK, LAT, busy, done, read_buf;
  logic [N_CH-1:0] SOUT;
  logic [N_CH*FC_W-1:0] fc_out;

  led_band_sequencer #(
    .N_CH(N_CH), .N_ROWS(N_ROWS), .N_ANGLES(N_ANGLES), .N_COLORS(N_COLORS),
    .BPC(BPC), .WORD_W(WORD_W), .FC_W(FC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .w_addr(w_addr), .w_data(w_data),
    .new_frame(new_frame), .start(start), .angle(angle), .lsb_first(lsb_first),
    .hps_override(hps_override), .hps_SOUT(hps_SOUT), .hps_SCLK(hps_SCLK), .hps_LAT(hps_LAT),
    .hps_fc_write(hps_fc_write), .hps_fc_addr(hps_fc_addr), .hps_fc_data(hps_fc_data),
    .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT), .busy(busy), .done(done),
    .read_buf(read_buf), .fc_out(fc_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] ref_mem [2][DEPTH*BPW];
  logic [N_CH-1:0] exp_q [$];
  bit rb = 1'b1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_write(input bit bsel, input int addr, input logic [WORD_W-1:0] d);
    for (int k = 0; k < BPW; k++) ref_mem[bsel][addr*BPW + k] = d[8*k +: 8];
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int j = 0; j < WORD_W/32; j++) w[32*j +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [N_CH-1:0] exp_bits(input bit bsel, input int ang, input bit lsb, input int n);
    int row, col, b;
    logic [7:0] by;
    logic [N_CH-1:0] r;
    row = n / (N_COLORS*BPC);
    col = (n / BPC) % N_COLORS;
    b   = lsb ? (n % BPC) : (BPC - 1 - (n % BPC));
    for (int ch = 0; ch < N_CH; ch++) begin
      by = ref_mem[bsel][col + N_COLORS*ang + N_COLORS*N_ANGLES*row + N_COLORS*N_ANGLES*N_ROWS*ch];
      r[ch] = by[b];
    end
    return r;
  endfunction

  // Called at a negedge; edge 0 is the posedge that samples start.
  task automatic run_seq(input int ang, input bit lsb, input int nf_a, input int nf_b,
                         input int wr_at, input int ovr_at, input int rst_at);
    int pulses = 0, saw_done = 0, saw_lat = 0;
    bit aborted = 0, prev = 0;
    logic [WORD_W-1:0] wd;
    logic [N_CH-1:0] e;
    exp_q.delete();
    for (int n = 0; n < NB; n++) exp_q.push_back(exp_bits(rb, ang, lsb, n));
    angle = ANW'(ang); lsb_first = lsb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      new_frame = (k == nf_a) || (k == nf_b);
      write = 1'b0;
      if (wr_at > 0 && k >= wr_at && k < wr_at + DEPTH) begin
        wd = rand_word();
        write = 1'b1; w_addr = AW'(k - wr_at); w_data = wd;
        model_write(!rb, k - wr_at, wd);
      end
      if (k == ovr_at) begin
        hps_override = 1'b1; hps_SOUT = 1'b1; hps_SCLK = 1'b1; hps_LAT = 1'b1;
        #1;
        chk("ovr_sout_hi", SOUT, 2'b11); chk("ovr_sclk_hi", SCLK, 1); chk("ovr_lat_hi", LAT, 1);
        hps_SOUT = 1'b0; hps_SCLK = 1'b0; hps_LAT = 1'b0;
        #1;
        chk("ovr_sout_lo", SOUT, 0); chk("ovr_sclk_lo", SCLK, 0); chk("ovr_lat_lo", LAT, 0);
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_sclk", SCLK, 0); chk("rst_lat", LAT, 0); chk("rst_sout", SOUT, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_read_buf", read_buf, 1); chk("rst_fc", fc_out, 0);
        rb = 1'b1;
        aborted = 1;
      end
      @(posedge clk);
      @(negedge clk);
      if (k == rst_at) rst_n = 1'b1;
      saw_done += int'(done);
      if (!hps_override) begin
        saw_lat += int'(LAT);
        if (!aborted && k >= 2 && k <= 2*NB && (k % 2) == 0 && exp_q.size() > 0)
          chk("sout_lo", SOUT, exp_q[0]);
        if (SCLK && !prev) begin
          if (exp_q.size() == 0) chk("extra_pulse", k, 0);
          else begin
            e = exp_q.pop_front();
            chk("sout_hi", SOUT, e);
            chk("sclk_edge", k, 3 + 2*pulses);
          end
          pulses++;
        end
      end
      prev = SCLK;
      if (k == 1 && !aborted) chk("busy_edge1", busy, 1);
      if (k == ovr_at) begin chk("ovr_abort_busy", busy, 0); aborted = 1; end
      if (!aborted && k == 2*NB + 2) begin
        chk("latch_lat", LAT, 1); chk("latch_done", done, 1); chk("latch_sclk", SCLK, 0);
      end
      if (!aborted && k == 2*NB + 3) begin
        chk("end_busy", busy, 0); chk("end_lat", LAT, 0); chk("end_done", done, 0);
      end
      if (nf_a > 0 && k == nf_a) chk("nf_hold", read_buf, rb);
      if (nf_a > 0 && k == 2*NB + 1) chk("nf_pre_done", read_buf, rb);
      if (nf_a > 0 && k == 2*NB + 2) chk("nf_toggle", read_buf, !rb);
      if (nf_a > 0 && k == 2*NB + 3) chk("nf_single", read_buf, !rb);
    end
    new_frame = 1'b0; write = 1'b0;
    if (nf_a > 0) rb = !rb;
    if (!aborted) begin
      chk("pulses", pulses, NB); chk("done_cnt", saw_done, 1); chk("queue_empty", exp_q.size(), 0);
    end else begin
      chk("abort_done", saw_done, 0); chk("abort_lat", saw_lat, 0);
    end
  endtask

  initial begin
    logic [WORD_W-1:0] wd;
    logic [FC_W-1:0] fcv;
    #2 rst_n = 1'b0;
    #3;
    chk("reset_read_buf", read_buf, 1); chk("reset_busy", busy, 0); chk("reset_sclk", SCLK, 0);
    chk("reset_lat", LAT, 0); chk("reset_sout", SOUT, 0); chk("reset_done", done, 0);
    chk("reset_fc", fc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      wd = rand_word();
      write = 1'b1; w_addr = AW'(a); w_data = wd;
      model_write(!rb, a, wd);
      @(negedge clk);
    end
    write = 1'b0;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    rb = !rb;
    chk("idle_swap", read_buf, 0);

    run_seq(1, 1'b0, 0, 0, 0, 0, 0);
    run_seq(2, 1'b1, 10, 20, 40, 0, 0);
    chk("after_swap", read_buf, 1);
    run_seq(3, 1'b0, 0, 0, 0, 30, 0);

    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ovr_start_ignored", busy, 0);
    end
    start = 1'b0;
    @(negedge clk);
    hps_override = 1'b0;
    @(negedge clk);
    chk("ovr_release_busy", busy, 0);
    chk("ovr_release_sclk", SCLK, 0);

    fcv = 48'hA5A5_0F0F_1234;
    hps_fc_write = 1'b1; hps_fc_addr = 1'b1; hps_fc_data = fcv;
    @(negedge clk);
    hps_fc_write = 1'b0;
    chk("fc_ch1", fc_out[2*FC_W-1:FC_W], fcv);
    chk("fc_ch0_zero", fc_out[FC_W-1:0], 0);
    fcv = 48'h1111_2222_3333;
    hps_fc_write = 1'b1; hps_fc_addr = 1'b0; hps_fc_data = fcv;
    @(negedge clk);
    hps_fc_write = 1'b0;
    chk("fc_ch0", fc_out[FC_W-1:0], fcv);
    chk("fc_ch1_kept", fc_out[2*FC_W-1:FC_W], 48'hA5A5_0F0F_1234);

    run_seq(0, 1'b0, 0, 0, 0, 0, 50);
    run_seq(2, 1'b0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
